// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, drives the
// asynchronous instruction-memory address, and latches instruction + PC+1 for decode.
module fetch_stage #(
  parameter int unsigned          DataWidth  = 16,
  parameter int unsigned          PCWidth    = 8,
  parameter logic [3:0]           HaltOpcode = 4'hF,
  parameter logic [DataWidth-1:0] NopInstr   = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PCWidth-1:0]   branch_target,
  output logic [PCWidth-1:0]   imem_addr,
  input  logic [DataWidth-1:0] imem_data,
  output logic [DataWidth-1:0] id_instr,
  output logic [PCWidth-1:0]   id_pc_plus1,
  output logic                 id_valid,
  output logic                 halted,
  output logic [15:0]          fetch_count
);

  typedef enum logic {
    S_FETCH,
    S_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic [PCWidth-1:0]     pc_q, pc_d;
  logic [DataWidth-1:0]   instr_q, instr_d;
  logic [PCWidth-1:0]     pcp1_q, pcp1_d;
  logic                   valid_q, valid_d;
  logic [15:0]            count_q, count_d;
  logic [PCWidth-1:0]     pc_plus1;
  logic                   is_halt;

  assign pc_plus1 = pc_q + PCWidth'(1);
  assign is_halt  = (imem_data[DataWidth-1:DataWidth-4] == HaltOpcode);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      instr_q <= NopInstr;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Halted state emits bubbles regardless of stall; only a redirect leaves it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch_taken) begin
      state_d = S_FETCH;
      pc_d    = branch_target;
      instr_d = NopInstr;
      pcp1_d  = '0;
      valid_d = 1'b0;
    end else if (state_q == S_HALTED) begin
      instr_d = NopInstr;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem_data;
      pcp1_d  = pc_plus1;
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
      if (is_halt) begin
        state_d = S_HALTED;
      end else begin
        pc_d = pc_plus1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus1 = pcp1_q;
  assign id_valid    = valid_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = count_q;

endmodule
